mcu_spi_mux: RTL and testbench
==============================

MCU_SPI_MUX -- requirements
Module: mcu_spi_mux

Interface
REQ-001 SHALL have parameter CHANNELS, default 2, number of MCU SPI ports (2..8); channel 0 is the on-board MCU.
REQ-002 SHALL have parameter DEFAULT_CH, default 0, channel selected after reset and on timeout revert.
REQ-003 SHALL have parameter FILTER, default 3, consecutive synced-low cycles of a candidate csn required before it counts as a request (1..15).
REQ-004 SHALL have parameter TIMEOUT, default 0, idle cycles after which a non-default selection reverts to DEFAULT_CH; 0 means sticky, never revert.
REQ-005 SHALL have parameter BROADCAST, default 1: 1 drives miso/intn to all channels; 0 drives only the selected channel, others held miso=0, intn_n=1.
REQ-006 clk32  in  1  system clock; the only clock.
REQ-007 por_n  in  1  reset; asynchronous assert, active-low.
REQ-008 ch_sclk, ch_csn, ch_mosi  in  CHANNELS each  raw asynchronous SPI inputs from each MCU.
REQ-009 ch_miso, ch_intn_n  out  CHANNELS each  FPGA-to-MCU data and interrupt per channel.
REQ-010 mcu_sclk, mcu_csn, mcu_mosi  out  1 each  synchronised selected bus to the core.
REQ-011 mcu_miso, mcu_intn_n  in  1 each  from the core.
REQ-012 lock  in  1  high freezes the current selection (no switch, no revert).
REQ-013 sel  out  clog2(CHANNELS)  currently selected channel.
REQ-014 switch_evt  out  1  one-cycle pulse when sel changes.

Function
REQ-015 Each ch_sclk/ch_csn/ch_mosi SHALL pass a 2-flop synchroniser; bus latency raw input to mcu_* is exactly 2 clk32 cycles.
REQ-016 mcu_sclk/mcu_mosi/mcu_csn SHALL equal the synced signals of channel sel, except mcu_csn is forced 1 in state SWITCH.
REQ-017 Per-channel filter counter SHALL count synced csn-low cycles, saturate at FILTER, clear on any synced csn high; request[i] = (count==FILTER).
REQ-018 FSM states: IDLE (selected csn high), BUSY (selected csn low), SWITCH (one cycle, csn forced high).
REQ-019 IDLE->BUSY when selected synced csn=0; BUSY->IDLE when it returns to 1.
REQ-020 IDLE->SWITCH when lock=0 and any request[i] with i!=sel; target = lowest such index.
REQ-021 In BUSY a foreign request SHALL NOT switch; it is served only after return to IDLE if still asserted (deasserted request is dropped).
REQ-022 On SWITCH entry sel SHALL update to target and switch_evt pulse for that cycle; SWITCH->IDLE next cycle unconditionally.
REQ-023 Idle counter SHALL count IDLE cycles while sel!=DEFAULT_CH, clear in BUSY/SWITCH; at TIMEOUT (if nonzero, lock=0) SHALL go SWITCH with target DEFAULT_CH.
REQ-024 A foreign request and timeout in the same cycle: request wins.
REQ-025 BROADCAST=1: ch_miso[i]=mcu_miso, ch_intn_n[i]=mcu_intn_n for all i, combinational.
REQ-026 Idle counter width SHALL hold TIMEOUT without wrap; filter counters saturate, never wrap.

Reset
REQ-027 While por_n=0: sel=DEFAULT_CH, state IDLE, counters 0, synchronisers 1 for csn and 0 for sclk/mosi, mcu_csn=1, mcu_sclk=0, mcu_mosi=0, switch_evt=0.
REQ-028 Reset asserted mid-transfer SHALL immediately force mcu_csn=1 and discard pending requests; first post-reset cycle starts in IDLE.

Structure
REQ-029 Package mcu_spi_mux_pkg SHALL hold the FSM state enum and CH_W = clog2(CHANNELS) helper.
REQ-030 Sub-module mcu_spi_sync (2-flop synchroniser plus csn filter for one channel) SHALL be instantiated CHANNELS times.

Verification
REQ-031 Reset, CHANNELS=2: sel=0, mcu_csn=1; ch_csn[0] low 10 cycles -> mcu_csn low 2 cycles later, no switch_evt.
REQ-032 ch_csn[1] low 3 cycles while channel 0 idle -> switch_evt once, sel=1, mcu_csn high during SWITCH cycle; 2-cycle glitch -> no switch.
REQ-033 ch_csn[1] low during channel 0 transfer -> sel stays 0 until ch_csn[0] high, then sel=1 next eligible cycle.
REQ-034 CHANNELS=4, ch_csn[2] and ch_csn[3] low same cycle -> sel=2.
REQ-035 TIMEOUT=100, sel=1, no activity 100 cycles -> sel=0, switch_evt; lock=1 -> sel stays 1.
REQ-036 BROADCAST=0, sel=1: ch_miso[0]=0, ch_intn_n[0]=1, ch_miso[1] follows mcu_miso.

Source files
------------

// File: rtl/mcu_spi_mux_pkg.sv
// rtl/mcu_spi_mux_pkg.sv - shared types and helpers for the MCU SPI port multiplexer
package mcu_spi_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    function automatic int ch_w(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/mcu_spi_sync.sv
// rtl/mcu_spi_sync.sv - 2-flop synchroniser and chip-select request filter for one MCU port
module mcu_spi_sync #(
    parameter int FILTER = 3
) (
    input  logic clk32,
    input  logic por_n,
    input  logic sclk,
    input  logic csn,
    input  logic mosi,
    output logic sclk_s,
    output logic csn_s,
    output logic mosi_s,
    output logic request
);

    localparam int FW = $clog2(FILTER + 1);

    logic [1:0]    sclk_ff;
    logic [1:0]    csn_ff;
    logic [1:0]    mosi_ff;
    logic [FW-1:0] cnt;

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n) begin
            sclk_ff <= 2'b00;
            csn_ff  <= 2'b11;
            mosi_ff <= 2'b00;
            cnt     <= '0;
        end else begin
            sclk_ff <= {sclk_ff[0], sclk};
            csn_ff  <= {csn_ff[0], csn};
            mosi_ff <= {mosi_ff[0], mosi};
            // Saturating count of synced-low cycles; any high sample restarts it
            if (csn_ff[1])
                cnt <= '0;
            else if (cnt != FW'(FILTER))
                cnt <= cnt + 1'b1;
        end
    end

    assign sclk_s  = sclk_ff[1];
    assign csn_s   = csn_ff[1];
    assign mosi_s  = mosi_ff[1];
    assign request = (cnt == FW'(FILTER));

endmodule

// File: rtl/mcu_spi_mux.sv
// rtl/mcu_spi_mux.sv - arbitrates several MCU SPI masters onto one synchronised core bus
module mcu_spi_mux
    import mcu_spi_mux_pkg::*;
#(
    parameter int CHANNELS   = 2,
    parameter int DEFAULT_CH = 0,
    parameter int FILTER     = 3,
    parameter int TIMEOUT    = 0,
    parameter int BROADCAST  = 1,
    localparam int CH_W      = ch_w(CHANNELS)
) (
    input  logic                clk32,
    input  logic                por_n,
    input  logic [CHANNELS-1:0] ch_sclk,
    input  logic [CHANNELS-1:0] ch_csn,
    input  logic [CHANNELS-1:0] ch_mosi,
    output logic [CHANNELS-1:0] ch_miso,
    output logic [CHANNELS-1:0] ch_intn_n,
    output logic                mcu_sclk,
    output logic                mcu_csn,
    output logic                mcu_mosi,
    input  logic                mcu_miso,
    input  logic                mcu_intn_n,
    input  logic                lock,
    output logic [CH_W-1:0]     sel,
    output logic                switch_evt
);

    localparam int TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    logic [CHANNELS-1:0] sclk_s, csn_s, mosi_s, request;
    state_t              state, next_state;
    logic [CH_W-1:0]     next_sel, target;
    logic                found, timeout_hit;
    logic [TW-1:0]       idle_cnt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        mcu_spi_sync #(.FILTER(FILTER)) u_sync (
            .clk32   (clk32),
            .por_n   (por_n),
            .sclk    (ch_sclk[i]),
            .csn     (ch_csn[i]),
            .mosi    (ch_mosi[i]),
            .sclk_s  (sclk_s[i]),
            .csn_s   (csn_s[i]),
            .mosi_s  (mosi_s[i]),
            .request (request[i])
        );
    end

    // Lowest-numbered foreign channel with a filtered request
    always_comb begin
        found  = 1'b0;
        target = CH_W'(DEFAULT_CH);
        for (int i = 0; i < CHANNELS; i++) begin
            if (!found && request[i] && (CH_W'(i) != sel)) begin
                found  = 1'b1;
                target = CH_W'(i);
            end
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (sel != CH_W'(DEFAULT_CH)) && (idle_cnt == TW'(TLIM));

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        next_sel   = sel;
        case (state)
            ST_IDLE: begin
                if (!csn_s[sel]) begin
                    next_state = ST_BUSY;
                end else if (!lock && found) begin
                    next_state = ST_SWITCH;
                    next_sel   = target;
                end else if (!lock && timeout_hit) begin
                    next_state = ST_SWITCH;
                    next_sel   = CH_W'(DEFAULT_CH);
                end
            end
            ST_BUSY:   if (csn_s[sel]) next_state = ST_IDLE;
            ST_SWITCH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk32 or negedge por_n) begin
        if (!por_n) begin
            sel      <= CH_W'(DEFAULT_CH);
            idle_cnt <= '0;
        end else begin
            sel <= next_sel;
            if (state == ST_IDLE && sel != CH_W'(DEFAULT_CH)) begin
                if (idle_cnt != TW'(TLIM))
                    idle_cnt <= idle_cnt + 1'b1;
            end else begin
                idle_cnt <= '0;
            end
        end
    end

    always_comb begin
        mcu_csn    = (state == ST_SWITCH) ? 1'b1 : csn_s[sel];
        mcu_sclk   = sclk_s[sel];
        mcu_mosi   = mosi_s[sel];
        switch_evt = (state == ST_SWITCH);
        ch_miso    = '0;
        ch_intn_n  = '1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (BROADCAST != 0 || CH_W'(i) == sel) begin
                ch_miso[i]   = mcu_miso;
                ch_intn_n[i] = mcu_intn_n;
            end
        end
    end

endmodule

// File: tb/tb_mcu_spi_mux.sv
// tb/tb_mcu_spi_mux.sv - scoreboard bench for mcu_spi_mux (2-channel sticky and 4-channel timeout variants)
module tb_mcu_spi_mux;

    logic clk32 = 1'b0;
    logic por_n = 1'b0;
    always #5 clk32 = ~clk32;

    // Variant A: CHANNELS=2, sticky, broadcast
    logic [1:0] sclk_a = '0, csn_a = '1, mosi_a = '0;
    logic [1:0] miso_out_a, intn_out_a;
    logic       mcu_sclk_a, mcu_csn_a, mcu_mosi_a;
    logic       miso_a = 1'b0, intn_a = 1'b1, lock_a = 1'b0;
    logic       sel_a, evt_a;

    // Variant B: CHANNELS=4, TIMEOUT=100, selected-only miso/intn
    logic [3:0] sclk_b = '0, csn_b = '1, mosi_b = '0;
    logic [3:0] miso_out_b, intn_out_b;
    logic       mcu_sclk_b, mcu_csn_b, mcu_mosi_b;
    logic       miso_b = 1'b0, intn_b = 1'b1, lock_b = 1'b0;
    logic [1:0] sel_b;
    logic       evt_b;

    mcu_spi_mux #(.CHANNELS(2), .DEFAULT_CH(0), .FILTER(3), .TIMEOUT(0), .BROADCAST(1)) dut_a (
        .clk32(clk32), .por_n(por_n),
        .ch_sclk(sclk_a), .ch_csn(csn_a), .ch_mosi(mosi_a),
        .ch_miso(miso_out_a), .ch_intn_n(intn_out_a),
        .mcu_sclk(mcu_sclk_a), .mcu_csn(mcu_csn_a), .mcu_mosi(mcu_mosi_a),
        .mcu_miso(miso_a), .mcu_intn_n(intn_a),
        .lock(lock_a), .sel(sel_a), .switch_evt(evt_a)
    );

    mcu_spi_mux #(.CHANNELS(4), .DEFAULT_CH(0), .FILTER(3), .TIMEOUT(100), .BROADCAST(0)) dut_b (
        .clk32(clk32), .por_n(por_n),
        .ch_sclk(sclk_b), .ch_csn(csn_b), .ch_mosi(mosi_b),
        .ch_miso(miso_out_b), .ch_intn_n(intn_out_b),
        .mcu_sclk(mcu_sclk_b), .mcu_csn(mcu_csn_b), .mcu_mosi(mcu_mosi_b),
        .mcu_miso(miso_b), .mcu_intn_n(intn_b),
        .lock(lock_b), .sel(sel_b), .switch_evt(evt_b)
    );

    int checks   = 0;
    int failures = 0;
    int q_a[$];
    int q_b[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk32);
        #1;
    endtask

    task automatic drain_a(input string name, input int bound);
        int n = 0;
        while (q_a.size() != 0 && n < bound) begin
            @(negedge clk32);
            n++;
        end
        chk(name, q_a.size(), 0);
        q_a.delete();
    endtask

    task automatic drain_b(input string name, input int bound);
        int n = 0;
        while (q_b.size() != 0 && n < bound) begin
            @(negedge clk32);
            n++;
        end
        chk(name, q_b.size(), 0);
        q_b.delete();
    endtask

    // Monitors: every switch_evt must match a queued expected selection
    always @(negedge clk32) begin
        if (por_n && evt_a) begin
            if (q_a.size() == 0) begin
                chk("a_unexpected_switch", int'(sel_a), -1);
            end else begin
                automatic int exp = q_a.pop_front();
                chk("a_switch_sel", int'(sel_a), exp);
                chk("a_switch_csn_forced", int'(mcu_csn_a), 1);
            end
        end
        if (por_n && evt_b) begin
            if (q_b.size() == 0) begin
                chk("b_unexpected_switch", int'(sel_b), -1);
            end else begin
                automatic int exp = q_b.pop_front();
                chk("b_switch_sel", int'(sel_b), exp);
                chk("b_switch_csn_forced", int'(mcu_csn_b), 1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        chk("rst_sel_a", int'(sel_a), 0);
        chk("rst_csn_a", int'(mcu_csn_a), 1);
        chk("rst_sclk_a", int'(mcu_sclk_a), 0);
        chk("rst_mosi_a", int'(mcu_mosi_a), 0);
        chk("rst_evt_a", int'(evt_a), 0);
        chk("rst_sel_b", int'(sel_b), 0);
        por_n = 1'b1;
        tick(2);

        // Channel 0 transfer: two-cycle latency, no switch
        csn_a[0] = 1'b0; sclk_a[0] = 1'b1; mosi_a[0] = 1'b1;
        tick(1);
        chk("lat1_csn", int'(mcu_csn_a), 1);
        tick(1);
        chk("lat2_csn", int'(mcu_csn_a), 0);
        chk("lat2_sclk", int'(mcu_sclk_a), 1);
        chk("lat2_mosi", int'(mcu_mosi_a), 1);
        tick(8);
        csn_a[0] = 1'b1; sclk_a[0] = 1'b0; mosi_a[0] = 1'b0;
        tick(4);
        chk("ch0_end_csn", int'(mcu_csn_a), 1);
        chk("ch0_end_sel", int'(sel_a), 0);

        // Three-cycle request on channel 1 while idle
        q_a.push_back(1);
        csn_a[1] = 1'b0;
        tick(3);
        csn_a[1] = 1'b1;
        drain_a("sw_to1_seen", 12);
        tick(2);

        // Two-cycle glitch on channel 0 must not switch
        csn_a[0] = 1'b0;
        tick(2);
        csn_a[0] = 1'b1;
        tick(8);
        chk("glitch_sel", int'(sel_a), 1);

        // Return to channel 0
        q_a.push_back(0);
        csn_a[0] = 1'b0;
        tick(3);
        csn_a[0] = 1'b1;
        drain_a("sw_to0_seen", 12);
        tick(2);

        // Foreign request during a transfer waits for the transfer to end
        csn_a[0] = 1'b0;
        tick(4);
        csn_a[1] = 1'b0;
        tick(10);
        chk("busy_hold_sel", int'(sel_a), 0);
        chk("busy_hold_csn", int'(mcu_csn_a), 0);
        q_a.push_back(1);
        csn_a[0] = 1'b1;
        drain_a("busy_release_seen", 12);
        tick(2);
        chk("ch1_busy_csn", int'(mcu_csn_a), 0);
        csn_a[1] = 1'b1;
        tick(4);

        // Lock freezes selection
        lock_a = 1'b1;
        csn_a[0] = 1'b0;
        tick(6);
        csn_a[0] = 1'b1;
        tick(5);
        lock_a = 1'b0;
        tick(5);
        chk("lock_a_sel", int'(sel_a), 1);

        // Broadcast: all channels follow core
        miso_a = 1'b1; intn_a = 1'b0;
        #1;
        chk("bc_miso_hi", int'(miso_out_a), 3);
        chk("bc_intn_lo", int'(intn_out_a), 0);
        miso_a = 1'b0; intn_a = 1'b1;
        #1;
        chk("bc_miso_lo", int'(miso_out_a), 0);
        chk("bc_intn_hi", int'(intn_out_a), 3);

        // Simultaneous requests on channels 2 and 3: lowest wins
        q_b.push_back(2);
        csn_b[2] = 1'b0; csn_b[3] = 1'b0;
        drain_b("pri_seen", 12);
        tick(2);
        chk("pri_sel", int'(sel_b), 2);
        chk("pri_csn", int'(mcu_csn_b), 0);
        csn_b[2] = 1'b1; csn_b[3] = 1'b1;
        tick(4);
        chk("pri_after_sel", int'(sel_b), 2);

        // Timeout revert from channel 1 after 100 idle cycles
        q_b.push_back(1);
        csn_b[1] = 1'b0;
        tick(3);
        csn_b[1] = 1'b1;
        drain_b("to1_seen", 12);
        tick(95);
        chk("timeout_not_early", int'(sel_b), 1);
        q_b.push_back(0);
        drain_b("timeout_seen", 20);
        tick(1);
        chk("timeout_sel", int'(sel_b), 0);

        // Lock blocks timeout revert
        q_b.push_back(1);
        csn_b[1] = 1'b0;
        tick(3);
        csn_b[1] = 1'b1;
        drain_b("to1_again_seen", 12);
        lock_b = 1'b1;
        tick(150);
        chk("lock_b_sel", int'(sel_b), 1);

        // Selected-only miso/intn with sel=1
        miso_b = 1'b1; intn_b = 1'b0;
        #1;
        chk("nb_miso", int'(miso_out_b), 2);
        chk("nb_intn", int'(intn_out_b), 13);
        miso_b = 1'b0; intn_b = 1'b1;
        #1;
        chk("nb_miso_lo", int'(miso_out_b), 0);
        chk("nb_intn_hi", int'(intn_out_b), 15);

        // Releasing lock lets the expired timeout revert
        q_b.push_back(0);
        lock_b = 1'b0;
        drain_b("unlock_revert_seen", 6);

        // Reset mid-transfer on A
        csn_a[1] = 1'b0;
        tick(4);
        chk("pre_rst_csn", int'(mcu_csn_a), 0);
        #3;
        por_n = 1'b0;
        #1;
        chk("mid_rst_csn", int'(mcu_csn_a), 1);
        chk("mid_rst_sel", int'(sel_a), 0);
        chk("mid_rst_evt", int'(evt_a), 0);
        csn_a[1] = 1'b1;
        tick(2);
        por_n = 1'b1;
        tick(6);
        chk("post_rst_csn", int'(mcu_csn_a), 1);
        chk("post_rst_sel", int'(sel_a), 0);
        chk("post_rst_q", q_a.size() + q_b.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
